// File: rtl/life_scan_ctrl.sv
// Scan/generation scheduler for a LED life matrix: scans cell positions with a
// dwell time per position, and hands memory to the generation engine between frames.
module life_scan_ctrl #(
    parameter int unsigned X      = 8,
    parameter int unsigned Y      = 8,
    parameter int unsigned LOG2X  = 3,
    parameter int unsigned LOG2Y  = 3,
    parameter int unsigned DWELL  = 16,
    parameter int unsigned FRAMES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   run,
    input  logic                   step,
    input  logic                   gen_ack,
    output logic [LOG2X+LOG2Y-1:0] cnt,
    output logic                   blank,
    output logic                   frame_done,
    output logic                   gen_req,
    output logic                   busy,
    output logic [15:0]            gen_count
);

    localparam int unsigned CW    = LOG2X + LOG2Y;
    localparam int unsigned DW    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned FW    = 8;
    localparam int unsigned CELLS = X * Y;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        GEN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   dwell_q, dwell_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            pend_q, pend_d;
    logic            fd_q, fd_d;
    logic            blank_q, blank_d;
    logic            req_q, req_d;
    logic [15:0]     gcnt_q, gcnt_d;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dwell_q <= '0;
            frame_q <= '0;
            pend_q  <= 1'b0;
            fd_q    <= 1'b0;
            blank_q <= 1'b1;
            req_q   <= 1'b0;
            gcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            frame_q <= frame_d;
            pend_q  <= pend_d;
            fd_q    <= fd_d;
            blank_q <= blank_d;
            req_q   <= req_d;
            gcnt_q  <= gcnt_d;
        end
    end

    // Next-state, counters and output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        frame_d = frame_q;
        pend_d  = pend_q | step;
        fd_d    = 1'b0;
        gcnt_d  = gcnt_q;

        case (state_q)
            IDLE: begin
                cnt_d   = '0;
                dwell_d = '0;
                frame_d = '0;
                if (enable) state_d = SCAN;
            end
            SCAN: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    dwell_d = '0;
                    frame_d = '0;
                end else if (dwell_q == DW'(DWELL - 1)) begin
                    dwell_d = '0;
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(CELLS - 1)) begin
                        cnt_d = '0;
                        fd_d  = 1'b1;
                        // Without a pending request the frame count parks at its last value
                        if (frame_q == FW'(FRAMES - 1)) begin
                            if (run || pend_q) begin
                                frame_d = '0;
                                state_d = GEN;
                            end
                        end else begin
                            frame_d = frame_q + FW'(1);
                        end
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            GEN: begin
                cnt_d   = '0;
                dwell_d = '0;
                if (gen_ack) begin
                    gcnt_d = gcnt_q + 16'd1;
                    if (enable) begin
                        state_d = SCAN;
                        pend_d  = step;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                dwell_d = '0;
                frame_d = '0;
            end
        endcase

        // Both derive from the same next state, so memory ownership stays exclusive
        blank_d = (state_d != SCAN);
        req_d   = (state_d == GEN);
    end

    assign cnt        = cnt_q;
    assign blank      = blank_q;
    assign frame_done = fd_q;
    assign gen_req    = req_q;
    assign busy       = req_q;
    assign gen_count  = gcnt_q;

endmodule

// File: tb/tb_life_scan_ctrl.sv
// Bench for life_scan_ctrl: directed scenarios plus random stimulus, all checked
// every cycle against a tick/frame-level behavioural model.
module tb_life_scan_ctrl;

    localparam int DWELL  = 4;
    localparam int FRAMES = 2;
    localparam int CELLS  = 64;
    localparam int TOTAL  = DWELL * CELLS;

    logic        clk = 1'b0;
    logic        reset, enable, run, step, gen_ack;
    logic [5:0]  cnt;
    logic        blank, frame_done, gen_req, busy;
    logic [15:0] gen_count;

    int n_tests = 0;
    int n_fail  = 0;

    life_scan_ctrl #(
        .X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .DWELL(DWELL), .FRAMES(FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .run(run), .step(step),
        .gen_ack(gen_ack), .cnt(cnt), .blank(blank), .frame_done(frame_done),
        .gen_req(gen_req), .busy(busy), .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0=idle 1=scan 2=gen; tick = clocks elapsed in the current frame
    int m_mode, m_tick, m_frames, m_gens;
    bit m_pend, m_fd, m_valid = 1'b0;

    always @(posedge clk) begin
        bit pend_old;
        if (!reset) begin
            m_mode = 0; m_tick = 0; m_frames = 0; m_gens = 0;
            m_pend = 1'b0; m_fd = 1'b0; m_valid = 1'b1;
        end else begin
            pend_old = m_pend;
            m_pend   = m_pend | step;
            m_fd     = 1'b0;
            case (m_mode)
                0: if (enable) m_mode = 1;
                1: begin
                    if (!enable) begin
                        m_mode = 0; m_tick = 0; m_frames = 0;
                    end else begin
                        m_tick++;
                        if (m_tick == TOTAL) begin
                            m_tick = 0;
                            m_fd   = 1'b1;
                            if (m_frames < FRAMES - 1) m_frames++;
                            else if (run || pend_old) begin
                                m_frames = 0;
                                m_mode   = 2;
                            end
                        end
                    end
                end
                default: if (gen_ack) begin
                    m_gens = (m_gens + 1) % 65536;
                    if (enable) begin
                        m_mode = 1;
                        m_pend = step;
                    end else begin
                        m_mode = 0;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_valid) begin
            check("cnt", int'(cnt), m_tick / DWELL);
            check("blank", int'(blank), (m_mode != 1) ? 1 : 0);
            check("gen_req", int'(gen_req), (m_mode == 2) ? 1 : 0);
            check("busy", int'(busy), (m_mode == 2) ? 1 : 0);
            check("frame_done", int'(frame_done), int'(m_fd));
            check("gen_count", int'(gen_count), m_gens);
            check("exclusive", int'(gen_req && !blank), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0; enable = 1'b0; run = 1'b0; step = 1'b0; gen_ack = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
    endtask

    task automatic wait_gen(output int n);
        n = 0;
        while (!gen_req && n < 1000) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n, hold, entries;
        bit saw_req, prev;

        reset = 1'b0; enable = 1'b0; run = 1'b0; step = 1'b0; gen_ack = 1'b0;
        do_reset();
        check("rst_cnt", int'(cnt), 0);
        check("rst_blank", int'(blank), 1);
        check("rst_gen_req", int'(gen_req), 0);
        check("rst_gen_count", int'(gen_count), 0);

        // Free scanning without updates
        enable = 1'b1;
        n = 0;
        while (!frame_done && n < 300) begin tick(); n++; end
        check("first_frame_done_clk", n, 257);
        saw_req = 1'b0;
        repeat (1743) begin tick(); if (gen_req) saw_req = 1'b1; end
        check("no_gen_req_2000", int'(saw_req), 0);

        // run=1: update after two frames
        do_reset();
        enable = 1'b1; run = 1'b1;
        wait_gen(n);
        check("run_gen_latency", n, 513);
        check("gen_blank", int'(blank), 1);
        check("gen_cnt", int'(cnt), 0);
        repeat (10) tick();
        gen_ack = 1'b1; tick(); gen_ack = 1'b0;
        check("ack_gen_req", int'(gen_req), 0);
        check("ack_busy", int'(busy), 0);
        check("ack_gen_count", int'(gen_count), 1);
        check("ack_blank", int'(blank), 0);
        check("ack_cnt", int'(cnt), 0);

        // Single step with run=0
        do_reset();
        enable = 1'b1; run = 1'b0;
        entries = 0; prev = 1'b0;
        for (int i = 1; i <= 1400; i++) begin
            tick();
            step = (i == 100);
            gen_ack = gen_req;
            if (gen_req && !prev) entries++;
            prev = gen_req;
        end
        step = 1'b0; gen_ack = 1'b0;
        check("step_gen_entries", entries, 1);
        check("step_gen_count", int'(gen_count), 1);

        // enable drop in GEN keeps the handshake alive
        do_reset();
        enable = 1'b1; run = 1'b1;
        wait_gen(n);
        check("en_gen_latency", n, 513);
        enable = 1'b0;
        hold = 0;
        repeat (20) begin tick(); if (gen_req) hold++; end
        check("en_gen_req_held", hold, 20);
        gen_ack = 1'b1; tick(); gen_ack = 1'b0;
        check("en_exit_gen_req", int'(gen_req), 0);
        check("en_exit_blank", int'(blank), 1);
        check("en_exit_gen_count", int'(gen_count), 1);
        tick();
        check("en_idle_blank", int'(blank), 1);
        check("en_idle_cnt", int'(cnt), 0);

        // Reset while gen_req is high, then stray acks during scan
        enable = 1'b1;
        wait_gen(n);
        check("rg_gen_seen", int'(gen_req), 1);
        reset = 1'b0; tick(); reset = 1'b1;
        check("rg_gen_req", int'(gen_req), 0);
        check("rg_gen_count", int'(gen_count), 0);
        check("rg_cnt", int'(cnt), 0);
        run = 1'b0; gen_ack = 1'b1;
        repeat (50) tick();
        gen_ack = 1'b0;
        check("stray_ack_gen_count", int'(gen_count), 0);
        check("stray_ack_blank", int'(blank), 0);

        // Random stimulus, checked by the model every cycle
        for (int i = 0; i < 6000; i++) begin
            reset   = ($urandom_range(0, 499) != 0);
            enable  = ($urandom_range(0, 99) < 95);
            run     = ($urandom_range(0, 99) < 30);
            step    = ($urandom_range(0, 99) < 1);
            gen_ack = ($urandom_range(0, 99) < 20);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
